// File: rtl/switch_arbiter_if.sv
// Request/grant bundle between the input-port queues, switch_arbiter and switch_fabric.
// The requester side is master; the arbiter is slave.
interface switch_arbiter_if #(
    parameter int N_PORTS = 8,
    parameter int ADDR_W  = 4
);
    logic [N_PORTS-1:0] req;
    logic [ADDR_W-1:0]  addr [N_PORTS-1:0];
    logic [N_PORTS-1:0] last;
    logic [N_PORTS-1:0] grant;
    logic [N_PORTS-1:0] busy;
    logic [N_PORTS-1:0] err;

    modport master (output req, addr, last, input grant, busy, err);
    modport slave  (input req, addr, last, output grant, busy, err);
endinterface

// File: rtl/switch_arbiter.sv
// Per-output round-robin arbiter. It holds each connection until the last beat or
// an abort, and re-arbitrates the freed output on the same edge.
module switch_arbiter #(
    parameter int N_PORTS = 8,
    parameter int ADDR_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    switch_arbiter_if.slave bus
);
    localparam int          IDXW     = $clog2(N_PORTS);
    localparam logic [31:0] NPORTS_U = 32'(N_PORTS);

    typedef logic [IDXW-1:0] idx_t;
    typedef enum logic {IDLE, HELD} state_e;

    state_e             state_q [N_PORTS];
    state_e             state_d [N_PORTS];
    idx_t               owner_q [N_PORTS];
    idx_t               owner_d [N_PORTS];
    idx_t               ptr_q   [N_PORTS];
    idx_t               ptr_d   [N_PORTS];
    logic [ADDR_W-1:0]  addr_seen_q [N_PORTS];
    logic [ADDR_W-1:0]  addr_seen_d [N_PORTS];
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [N_PORTS-1:0] busy_q, busy_d;
    logic [N_PORTS-1:0] err_q, err_d;
    logic [N_PORTS-1:0] flagged_q, flagged_d;
    logic [N_PORTS-1:0] addr_ok, release_c, elig;
    logic               found;
    idx_t               cand;

    always_comb begin
        addr_ok   = '0;
        release_c = '0;
        elig      = '0;
        flagged_d = '0;
        err_d     = '0;
        grant_d   = '0;
        busy_d    = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            addr_ok[i]     = (32'(bus.addr[i]) < NPORTS_U);
            release_c[i]   = grant_q[i] & (~bus.req[i] | bus.last[i]);
            // A releasing input may re-enter arbitration on the edge that frees it.
            elig[i]        = bus.req[i] & addr_ok[i] & (~grant_q[i] | release_c[i]);
            flagged_d[i]   = bus.req[i] & ~addr_ok[i];
            addr_seen_d[i] = bus.addr[i];
            err_d[i]       = flagged_d[i] & ~(flagged_q[i] & (addr_seen_q[i] == bus.addr[i]));
        end
        for (int unsigned o = 0; o < N_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            if (state_q[o] == HELD && release_c[owner_q[o]])
                state_d[o] = IDLE;
            if (state_d[o] == IDLE) begin
                found = 1'b0;
                for (int unsigned k = 0; k < N_PORTS; k++) begin
                    cand = ptr_q[o] + idx_t'(k);
                    if (!found && elig[cand] && bus.addr[cand][IDXW-1:0] == idx_t'(o)) begin
                        found      = 1'b1;
                        state_d[o] = HELD;
                        owner_d[o] = cand;
                        ptr_d[o]   = cand + idx_t'(1);
                    end
                end
            end
            if (state_d[o] == HELD) begin
                busy_d[o]          = 1'b1;
                grant_d[owner_d[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= '{default: IDLE};
            owner_q     <= '{default: '0};
            ptr_q       <= '{default: '0};
            addr_seen_q <= '{default: '0};
            grant_q     <= '0;
            busy_q      <= '0;
            err_q       <= '0;
            flagged_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            addr_seen_q <= addr_seen_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            flagged_q   <= flagged_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_switch_arbiter.sv
// Scoreboard bench for switch_arbiter. Each scenario queues the expected
// grant/busy/err for every edge it drives and checks them after that edge.
module tb_switch_arbiter;
    localparam int N  = 8;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    switch_arbiter_if #(.N_PORTS(N), .ADDR_W(AW)) bus ();
    switch_arbiter #(.N_PORTS(N), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic [7:0] g, b, e; } exp_t;
    typedef struct { logic [7:0] req, last, g, b, e; } row_t;

    exp_t sbq [$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic clear_inputs();
        bus.req  = '0;
        bus.last = '0;
        for (int i = 0; i < N; i++) bus.addr[i] = '0;
    endtask

    task automatic test_reset();
        exp_t exp, got;
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        sbq.push_back('{g: 8'h00, b: 8'h00, e: 8'h00});
        #1;
        exp = sbq.pop_front();
        got = '{bus.grant, bus.busy, bus.err};
        compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL reset grant got %h exp %h", got.g, exp.g); end
        compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL reset busy got %h exp %h", got.b, exp.b); end
        compared++; if (got.e !== exp.e) begin mismatched++; $display("FAIL reset err got %h exp %h", got.e, exp.e); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        exp_t exp, got;
        @(negedge clk);
        for (int i = 0; i < N; i++) bus.addr[i] = 4'd7;
        bus.req  = 8'hFF;
        bus.last = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            sbq.push_back('{g: 8'(1 << (k % 8)), b: 8'h80, e: 8'h00});
            @(posedge clk); #1;
            exp = sbq.pop_front();
            got = '{bus.grant, bus.busy, bus.err};
            compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL contention grant k=%0d got %h exp %h", k, got.g, exp.g); end
            compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL contention busy k=%0d got %h exp %h", k, got.b, exp.b); end
            compared++; if (got.e !== exp.e) begin mismatched++; $display("FAIL contention err k=%0d got %h exp %h", k, got.e, exp.e); end
        end
    endtask

    task automatic test_parallel();
        exp_t exp, got;
        row_t rows [3];
        rows = '{'{8'h43, 8'h00, 8'h03, 8'h28, 8'h00},
                 '{8'h43, 8'h01, 8'h42, 8'h28, 8'h00},
                 '{8'h42, 8'h00, 8'h42, 8'h28, 8'h00}};
        @(negedge clk);
        bus.addr[0] = 4'd3;
        bus.addr[1] = 4'd5;
        bus.addr[6] = 4'd3;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            bus.req  = rows[k].req;
            bus.last = rows[k].last;
            sbq.push_back('{rows[k].g, rows[k].b, rows[k].e});
            @(posedge clk); #1;
            exp = sbq.pop_front();
            got = '{bus.grant, bus.busy, bus.err};
            compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL parallel grant k=%0d got %h exp %h", k, got.g, exp.g); end
            compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL parallel busy k=%0d got %h exp %h", k, got.b, exp.b); end
            compared++; if (got.e !== exp.e) begin mismatched++; $display("FAIL parallel err k=%0d got %h exp %h", k, got.e, exp.e); end
        end
    endtask

    task automatic test_multi_beat();
        exp_t exp, got;
        row_t rows [6];
        rows = '{'{8'h24, 8'h00, 8'h04, 8'h10, 8'h00},
                 '{8'h24, 8'h00, 8'h04, 8'h10, 8'h00},
                 '{8'h24, 8'h00, 8'h04, 8'h10, 8'h00},
                 '{8'h24, 8'h00, 8'h04, 8'h10, 8'h00},
                 '{8'h24, 8'h04, 8'h20, 8'h10, 8'h00},
                 '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        @(negedge clk);
        bus.addr[2] = 4'd4;
        bus.addr[5] = 4'd4;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) @(negedge clk);
            bus.req  = rows[k].req;
            bus.last = rows[k].last;
            sbq.push_back('{rows[k].g, rows[k].b, rows[k].e});
            @(posedge clk); #1;
            exp = sbq.pop_front();
            got = '{bus.grant, bus.busy, bus.err};
            compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL multibeat grant k=%0d got %h exp %h", k, got.g, exp.g); end
            compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL multibeat busy k=%0d got %h exp %h", k, got.b, exp.b); end
            compared++; if (got.e !== exp.e) begin mismatched++; $display("FAIL multibeat err k=%0d got %h exp %h", k, got.e, exp.e); end
        end
    endtask

    task automatic test_invalid_addr();
        exp_t exp, got;
        row_t rows [7];
        rows = '{'{8'h08, 8'h00, 8'h00, 8'h00, 8'h08},
                 '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00},
                 '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00},
                 '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00},
                 '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00},
                 '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 '{8'h08, 8'h00, 8'h00, 8'h00, 8'h08}};
        @(negedge clk);
        bus.addr[3] = 4'b1000;
        for (int k = 0; k < 7; k++) begin
            if (k != 0) @(negedge clk);
            bus.req  = rows[k].req;
            bus.last = rows[k].last;
            sbq.push_back('{rows[k].g, rows[k].b, rows[k].e});
            @(posedge clk); #1;
            exp = sbq.pop_front();
            got = '{bus.grant, bus.busy, bus.err};
            compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL invalid grant k=%0d got %h exp %h", k, got.g, exp.g); end
            compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL invalid busy k=%0d got %h exp %h", k, got.b, exp.b); end
            compared++; if (got.e !== exp.e) begin mismatched++; $display("FAIL invalid err k=%0d got %h exp %h", k, got.e, exp.e); end
        end
    endtask

    task automatic test_abort();
        exp_t exp, got;
        row_t rows [5];
        // The last two rows show the pointer sat at 2 after the abort: input 2 beats input 1.
        rows = '{'{8'h02, 8'h00, 8'h02, 8'h04, 8'h00},
                 '{8'h02, 8'h00, 8'h02, 8'h04, 8'h00},
                 '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 '{8'h06, 8'h00, 8'h04, 8'h04, 8'h00},
                 '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        @(negedge clk);
        bus.addr[1] = 4'd2;
        bus.addr[2] = 4'd2;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            bus.req  = rows[k].req;
            bus.last = rows[k].last;
            sbq.push_back('{rows[k].g, rows[k].b, rows[k].e});
            @(posedge clk); #1;
            exp = sbq.pop_front();
            got = '{bus.grant, bus.busy, bus.err};
            compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL abort grant k=%0d got %h exp %h", k, got.g, exp.g); end
            compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL abort busy k=%0d got %h exp %h", k, got.b, exp.b); end
            compared++; if (got.e !== exp.e) begin mismatched++; $display("FAIL abort err k=%0d got %h exp %h", k, got.e, exp.e); end
        end
    endtask

    task automatic test_reset_mid_packet();
        exp_t exp, got;
        @(negedge clk);
        bus.addr[4] = 4'd0;
        bus.req     = 8'h10;
        sbq.push_back('{g: 8'h10, b: 8'h01, e: 8'h00});
        @(posedge clk); #1;
        exp = sbq.pop_front();
        got = '{bus.grant, bus.busy, bus.err};
        compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL midreset pre grant got %h exp %h", got.g, exp.g); end
        compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL midreset pre busy got %h exp %h", got.b, exp.b); end
        #1;
        rst_n = 1'b0;
        sbq.push_back('{g: 8'h00, b: 8'h00, e: 8'h00});
        #1;
        exp = sbq.pop_front();
        got = '{bus.grant, bus.busy, bus.err};
        compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL midreset grant got %h exp %h", got.g, exp.g); end
        compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL midreset busy got %h exp %h", got.b, exp.b); end
        compared++; if (got.e !== exp.e) begin mismatched++; $display("FAIL midreset err got %h exp %h", got.e, exp.e); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) bus.addr[i] = 4'd7;
        bus.req  = 8'hFF;
        bus.last = 8'hFF;
        sbq.push_back('{g: 8'h01, b: 8'h80, e: 8'h00});
        @(posedge clk); #1;
        exp = sbq.pop_front();
        got = '{bus.grant, bus.busy, bus.err};
        compared++; if (got.g !== exp.g) begin mismatched++; $display("FAIL midreset post grant got %h exp %h", got.g, exp.g); end
        compared++; if (got.b !== exp.b) begin mismatched++; $display("FAIL midreset post busy got %h exp %h", got.b, exp.b); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_contention();
        test_reset();
        test_parallel();
        test_reset();
        test_multi_beat();
        test_reset();
        test_invalid_addr();
        test_reset();
        test_abort();
        test_reset();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Per-output round-robin arbiter that generates the `grant` vector consumed by `switch_fabric`. Each input port raises a request carrying a destination address. The arbiter grants at most one input per output port, holds the connection until the packet's last beat or an abort, then re-arbitrates. It sits between the input-port queues and `switch_fabric`. Its `grant` drives the fabric's `grant` directly, and the same `addr` bus feeds both blocks.

## Interface
- `N_PORTS`, 8, number of input and output ports (power of two, 2..16)
- `ADDR_W`, 4, width of each destination address; low `$clog2(N_PORTS)` bits select the output
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  N_PORTS  per-input request; level, held until granted
- `addr`  in  N_PORTS x ADDR_W (unpacked `[N_PORTS-1:0]`)  per-input destination
- `last`  in  N_PORTS  per-input last-beat flag; qualified only while `grant[i]`=1
- `grant`  out  N_PORTS  registered one-hot-per-destination grant to `switch_fabric`
- `busy`  out  N_PORTS  per-output "connection held" flag, registered
- `err`  out  N_PORTS  one-cycle pulse: input i presented an invalid address

## Operation
- Valid address: `addr[i] < N_PORTS`. Any value ≥ N_PORTS (e.g. 4'b1000) is invalid.
  - An invalid address is never granted.
  - `err[i]` pulses for one cycle on the first cycle `req[i]`=1 with the invalid address.
  - `err[i]` re-arms when `req[i]` drops or `addr[i]` changes.
- Per output o, state is:
  - `owner[o]`: input index plus a valid bit; `busy[o]` = owner valid.
  - `ptr[o]`: round-robin pointer giving the highest-priority input.
- Per-output FSM has two states, IDLE and HELD.
  - IDLE → HELD: at least one eligible input exists. Input i is eligible when `req[i]`=1, the address is valid, `addr[i]`=o, and input i is not currently granted. The winner is the first eligible input scanning from `ptr[o]` upward, modulo N_PORTS.
  - On grant: `owner[o]` = winner, `grant[winner]` set, `ptr[o]` = (winner+1) mod N_PORTS.
  - HELD → release on either condition:
    - `grant[i]` & `req[i]` & `last[i]` at a clock edge (normal end of packet).
    - `grant[i]` & !`req[i]` (abort).
  - HELD with `req[i]` & !`last[i]` stays HELD, and the grant is held.
- Destination is latched at grant.
  - Changes to `addr[i]` while granted are ignored by the arbiter.
  - Requesters keep `addr` stable while granted, because the fabric routes on live `addr`.
- Release and re-arbitration happen in the same cycle.
  - An output freed at edge t can be granted to a new input at edge t.
  - This gives zero-bubble back-to-back packets.
  - The releasing input takes part in that arbitration but has lowest priority, because the pointer has already advanced past it.
- Invariants:
  - Each input is granted to at most one output.
  - Each output has at most one owner.
  - `grant` = OR over outputs of onehot(owner).
- Reset (asynchronous, `rst_n`=0): `grant`=0, `busy`=0, `err`=0, all owners invalid, all `ptr`=0. A packet in flight during reset is dropped; no release beat is required.

## Timing
- Request latency: `req[i]` first sampled high at edge t on a free output → `grant[i]`=1 after edge t (one cycle).
- Data beats: every cycle with `grant[i]`=1 is a transferred beat. A single-beat packet asserts `last` in its first granted cycle.
- Release: the `last` beat is sampled at edge t → `grant[i]`=0 after edge t.
- `busy[o]` follows the same edge as the corresponding grant set or clear.
- `err` is registered: asserted the cycle after the sampling edge, for exactly one cycle.
- Simultaneous requests to distinct outputs are granted in the same cycle.

## Test plan
- Contention, all 8 inputs → addr 7:
  - Stimulus: `req`=0xFF, `last`=1, `addr`=7 for all inputs, reset pointers.
  - Required response: `grant` cycles 0x01, 0x02, 0x04 … 0x80, then 0x01. One grant per cycle, no idle cycles, `busy[7]`=1 throughout.
- Parallel, distinct destinations:
  - Stimulus: input 0 → 3, input 1 → 5, input 6 → 3, all requesting at edge t.
  - Required response: `grant`=0x03 after t, with `busy`=0x28.
  - After input 0's last beat, `grant`=0x42.
- Multi-beat hold:
  - Stimulus: input 2 → 4 with a 4-beat packet (`last` on beat 4), while input 5 also requests output 4.
  - Required response: `grant[2]` high for exactly 4 cycles, then `grant[5]` in the next cycle.
- Invalid address:
  - Stimulus: `req[3]`=1 with `addr[3]`=4'b1000, held for 5 cycles.
  - Required response: a single `err[3]` pulse one cycle after the first sample, `grant[3]` stays 0, `busy` stays 0.
- Abort:
  - Stimulus: input 1 is granted output 2, then drops `req[1]` before `last`.
  - Required response: `grant[1]`=0 and `busy[2]`=0 next cycle, and `ptr[2]`=2.
- Reset mid-packet:
  - Stimulus: assert `rst_n`=0 asynchronously while `grant`=0x10.
  - Required response: `grant`, `busy`, `err` = 0 immediately.
  - After release, 8 contending inputs → first grant goes to input 0.
